// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundles for the cacheline burst adaptor.
//   cacheline_burst_adaptor_line_if : cache-side 256-bit line port (master = cache, slave = adaptor)
//   cacheline_burst_adaptor_mem_if  : memory-side 64-bit burst port (master = adaptor, slave = memory)

interface cacheline_burst_adaptor_line_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              line_read;
  logic              line_write;
  logic [ADDR_W-1:0] line_address;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;

  modport master (
    output line_read, line_write, line_address, line_wdata,
    input  line_rdata, line_resp
  );

  modport slave (
    input  line_read, line_write, line_address, line_wdata,
    output line_rdata, line_resp
  );
endinterface

interface cacheline_burst_adaptor_mem_if #(
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic               burst_read;
  logic               burst_write;
  logic [ADDR_W-1:0]  burst_address;
  logic [BURST_W-1:0] burst_wdata;
  logic [BURST_W-1:0] burst_rdata;
  logic               burst_resp;

  modport master (
    output burst_read, burst_write, burst_address, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport slave (
    input  burst_read, burst_write, burst_address, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Purpose : turns one cacheline read/write from the cache into a BEATS x BURST_W memory burst.
// Latency : accept edge, then one cycle per beat (zero-wait), then a single line_resp cycle.
// Backpr. : memory stalls by withholding burst_resp; request/address/wdata hold until it comes.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   line : cache side (slave)  - line_read/line_write/line_address/line_wdata in,
//                                line_rdata/line_resp out
//   mem  : memory side (master) - burst_read/burst_write/burst_address/burst_wdata out,
//                                burst_rdata/burst_resp in

module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int BEATS   = 4,
  parameter int ADDR_W  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  cacheline_burst_adaptor_line_if.slave   line,
  cacheline_burst_adaptor_mem_if.master   mem
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Byte offset bits within a line; these are cleared on the burst address.
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  // Shared line buffer: holds the write line during WR and assembles the fill during RD.
  logic [LINE_W-1:0] buf_q,   buf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    buf_d   = buf_q;

    case (state_q)
      IDLE: begin
        // Writeback takes priority so a dirty victim leaves before its refill arrives.
        if (line.line_write) begin
          addr_d  = line.line_address & ADDR_MASK;
          buf_d   = line.line_wdata;
          count_d = '0;
          state_d = WR;
        end else if (line.line_read) begin
          addr_d  = line.line_address & ADDR_MASK;
          count_d = '0;
          state_d = RD;
        end
      end

      RD: begin
        if (mem.burst_resp) begin
          buf_d[count_q * BURST_W +: BURST_W] = mem.burst_rdata;
          if (count_q == LAST_BEAT) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      WR: begin
        if (mem.burst_resp) begin
          if (count_q == LAST_BEAT) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        // Always spend one IDLE cycle before looking at the next request.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Every output is a decode of flopped state, so async reset drives them all to 0 at once.
  assign mem.burst_read    = (state_q == RD);
  assign mem.burst_write   = (state_q == WR);
  assign mem.burst_address = addr_q;
  assign mem.burst_wdata   = (state_q == WR) ? buf_q[count_q * BURST_W +: BURST_W]
                                             : '0;
  assign line.line_resp    = (state_q == DONE);
  assign line.line_rdata   = buf_q;

  a_resp_single : assert property (@(posedge clk) disable iff (!rst)
    line.line_resp |=> !line.line_resp);

  a_rd_wr_excl : assert property (@(posedge clk) disable iff (!rst)
    !(mem.burst_read && mem.burst_write));

  a_addr_stable : assert property (@(posedge clk) disable iff (!rst)
    (mem.burst_read || mem.burst_write) |=>
      (!(mem.burst_read || mem.burst_write) || $stable(mem.burst_address)));

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  cacheline_burst_adaptor_line_if #(.LINE_W(256), .ADDR_W(32)) lif ();
  cacheline_burst_adaptor_mem_if  #(.BURST_W(64), .ADDR_W(32)) mif ();

  cacheline_burst_adaptor #(
    .LINE_W (256),
    .BURST_W(64),
    .BEATS  (4),
    .ADDR_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .line(lif),
    .mem (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations from the last memory-model run.
  int          req_cycles;
  int          beats;
  int          resp_cnt;
  int          resp_cycle;
  logic [31:0] addr_seen;
  bit          addr_stable;
  bit          saw_rd;
  bit          saw_wr;
  bit          timed_out;
  logic [255:0] wr_seen;
  logic [255:0] rd_seen;

  // Memory model: called at posedge+1 in the cycle the cache request is raised.
  // Serves beats after 'waits' stall cycles, records what the DUT did, and drops the
  // cache request in the line_resp cycle (keeps line_read if keep_rd, and returns then).
  task automatic serve(input int waits, input logic [255:0] rd_line,
                       input bit stray, input bit keep_rd);
    int c;
    int wcnt;
    int tail;
    bit done;
    req_cycles = 0; beats = 0; resp_cnt = 0; resp_cycle = 0;
    addr_seen = '0; addr_stable = 1'b1; saw_rd = 1'b0; saw_wr = 1'b0;
    timed_out = 1'b0; wr_seen = '0; rd_seen = '0;
    c = 0; wcnt = 0; tail = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      c++;
      if (mif.burst_read || mif.burst_write) begin
        if (req_cycles == 0) addr_seen = mif.burst_address;
        else if (mif.burst_address !== addr_seen) addr_stable = 1'b0;
        req_cycles++;
        saw_rd = saw_rd | mif.burst_read;
        saw_wr = saw_wr | mif.burst_write;
        if (wcnt < waits) begin
          mif.burst_resp = 1'b0;
          wcnt++;
        end else begin
          mif.burst_resp  = 1'b1;
          mif.burst_rdata = rd_line[(beats % 4) * 64 +: 64];
          if (mif.burst_write) wr_seen[(beats % 4) * 64 +: 64] = mif.burst_wdata;
          beats++;
          wcnt = 0;
        end
      end else begin
        mif.burst_resp  = stray;
        mif.burst_rdata = stray ? 64'hDEAD_BEEF_BAAD_F00D : 64'h0;
      end
      if (lif.line_resp) begin
        resp_cnt++;
        if (resp_cnt == 1) begin
          resp_cycle = c;
          rd_seen = lif.line_rdata;
          lif.line_write = 1'b0;
          if (!keep_rd) lif.line_read = 1'b0;
          else done = 1'b1;
        end
      end
      if (resp_cnt > 0 && !keep_rd) begin
        tail++;
        if (tail > 3) done = 1'b1;
      end
      if (c > 300) begin
        timed_out = 1'b1;
        done = 1'b1;
      end
    end
    mif.burst_resp  = 1'b0;
    mif.burst_rdata = 64'h0;
    lif.line_read   = 1'b0;
    lif.line_write  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({mif.burst_read, mif.burst_write} !== 2'b00) begin fails++; $display("FAIL reset_req: got %b want 00", {mif.burst_read, mif.burst_write}); end
    checks++; if (mif.burst_address !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mif.burst_address); end
    checks++; if (mif.burst_wdata !== 64'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", mif.burst_wdata); end
    checks++; if (lif.line_rdata !== 256'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", lif.line_rdata); end
    checks++; if (lif.line_resp !== 1'b0) begin fails++; $display("FAIL reset_resp: got %b want 0", lif.line_resp); end
  endtask

  task automatic test_read_basic();
    logic [255:0] exp;
    exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    lif.line_address = 32'h0000_1234;
    lif.line_read = 1'b1;
    serve(0, exp, 1'b0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin fails++; $display("FAIL rd_timeout: no line_resp within budget"); end
    checks++; if (addr_seen !== 32'h0000_1220) begin fails++; $display("FAIL rd_addr: got %h want 00001220", addr_seen); end
    checks++; if (rd_seen !== exp) begin fails++; $display("FAIL rd_line: got %h want %h", rd_seen, exp); end
    checks++; if (resp_cnt !== 1) begin fails++; $display("FAIL rd_resp_cnt: got %0d want 1", resp_cnt); end
    checks++; if (resp_cycle !== 5) begin fails++; $display("FAIL rd_latency: got %0d want 5", resp_cycle); end
    checks++; if (req_cycles !== 4) begin fails++; $display("FAIL rd_req_cycles: got %0d want 4", req_cycles); end
    checks++; if (saw_wr !== 1'b0) begin fails++; $display("FAIL rd_no_write: got %b want 0", saw_wr); end
    checks++; if (lif.line_rdata !== exp) begin fails++; $display("FAIL rd_hold: got %h want %h", lif.line_rdata, exp); end
  endtask

  task automatic test_write();
    logic [255:0] wd;
    wd = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    lif.line_address = 32'h8000_0040;
    lif.line_wdata = wd;
    lif.line_write = 1'b1;
    serve(0, 256'h0, 1'b0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin fails++; $display("FAIL wr_timeout: no line_resp within budget"); end
    checks++; if (wr_seen !== wd) begin fails++; $display("FAIL wr_beats: got %h want %h", wr_seen, wd); end
    checks++; if (addr_seen !== 32'h8000_0040) begin fails++; $display("FAIL wr_addr: got %h want 80000040", addr_seen); end
    checks++; if (req_cycles !== 4) begin fails++; $display("FAIL wr_req_cycles: got %0d want 4", req_cycles); end
    checks++; if (resp_cycle !== 5) begin fails++; $display("FAIL wr_latency: got %0d want 5", resp_cycle); end
    checks++; if (saw_rd !== 1'b0) begin fails++; $display("FAIL wr_no_read: got %b want 0", saw_rd); end
    checks++; if (resp_cnt !== 1) begin fails++; $display("FAIL wr_resp_cnt: got %0d want 1", resp_cnt); end
  endtask

  task automatic test_wait_states();
    logic [255:0] exp;
    exp = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_0F0F_F0F0_F0F0};
    lif.line_address = 32'h0000_201F;
    lif.line_read = 1'b1;
    serve(3, exp, 1'b0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin fails++; $display("FAIL wait_timeout: no line_resp within budget"); end
    checks++; if (req_cycles !== 16) begin fails++; $display("FAIL wait_req_cycles: got %0d want 16", req_cycles); end
    checks++; if (addr_stable !== 1'b1) begin fails++; $display("FAIL wait_addr_stable: got %b want 1", addr_stable); end
    checks++; if (addr_seen !== 32'h0000_2000) begin fails++; $display("FAIL wait_addr: got %h want 00002000", addr_seen); end
    checks++; if (rd_seen !== exp) begin fails++; $display("FAIL wait_line: got %h want %h", rd_seen, exp); end
    checks++; if (resp_cnt !== 1) begin fails++; $display("FAIL wait_resp_cnt: got %0d want 1", resp_cnt); end
    checks++; if (resp_cycle !== 17) begin fails++; $display("FAIL wait_latency: got %0d want 17", resp_cycle); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] wd;
    logic [255:0] rl;
    wd = {64'h4040_4040_4040_4040, 64'h3030_3030_3030_3030,
          64'h2020_2020_2020_2020, 64'h1010_1010_1010_1010};
    rl = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
          64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
    lif.line_address = 32'h0000_0100;
    lif.line_wdata = wd;
    lif.line_read = 1'b1;
    lif.line_write = 1'b1;
    serve(0, rl, 1'b0, 1'b1);
    checks++; if ({saw_wr, saw_rd} !== 2'b10) begin fails++; $display("FAIL prio_kind: got wr,rd=%b want 10", {saw_wr, saw_rd}); end
    checks++; if (wr_seen !== wd) begin fails++; $display("FAIL prio_wdata: got %h want %h", wr_seen, wd); end
    checks++; if (addr_seen !== 32'h0000_0100) begin fails++; $display("FAIL prio_addr: got %h want 00000100", addr_seen); end
    // line_read stays high through DONE; the following cycle must still be IDLE.
    lif.line_read = 1'b1;
    @(posedge clk); #1;
    checks++; if ({mif.burst_read, mif.burst_write, lif.line_resp} !== 3'b000) begin fails++; $display("FAIL b2b_idle_gap: got rd,wr,resp=%b want 000", {mif.burst_read, mif.burst_write, lif.line_resp}); end
    serve(0, rl, 1'b0, 1'b0);
    checks++; if ({saw_wr, saw_rd} !== 2'b01) begin fails++; $display("FAIL b2b_kind: got wr,rd=%b want 01", {saw_wr, saw_rd}); end
    checks++; if (rd_seen !== rl) begin fails++; $display("FAIL b2b_line: got %h want %h", rd_seen, rl); end
    checks++; if (resp_cycle !== 5) begin fails++; $display("FAIL b2b_latency: got %0d want 5", resp_cycle); end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] rl;
    int           resp_seen;
    int           req_seen;
    rl = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
          64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    lif.line_address = 32'h0000_3008;
    lif.line_read = 1'b1;
    @(posedge clk); #1;
    checks++; if (mif.burst_read !== 1'b1) begin fails++; $display("FAIL rstmid_req: got %b want 1", mif.burst_read); end
    mif.burst_resp = 1'b1;
    mif.burst_rdata = rl[63:0];
    @(posedge clk); #1;
    mif.burst_rdata = rl[127:64];
    @(posedge clk); #1;
    mif.burst_resp = 1'b0;
    mif.burst_rdata = 64'h0;
    checks++; if (lif.line_rdata[127:0] !== rl[127:0]) begin fails++; $display("FAIL rstmid_partial: got %h want %h", lif.line_rdata[127:0], rl[127:0]); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({mif.burst_read, mif.burst_write, lif.line_resp} !== 3'b000) begin fails++; $display("FAIL rstmid_ctrl: got rd,wr,resp=%b want 000", {mif.burst_read, mif.burst_write, lif.line_resp}); end
    checks++; if (mif.burst_address !== 32'h0) begin fails++; $display("FAIL rstmid_addr: got %h want 0", mif.burst_address); end
    checks++; if (lif.line_rdata !== 256'h0) begin fails++; $display("FAIL rstmid_rdata: got %h want 0", lif.line_rdata); end
    lif.line_read = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    resp_seen = 0;
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (lif.line_resp) resp_seen++;
      if (mif.burst_read || mif.burst_write) req_seen++;
    end
    checks++; if (resp_seen !== 0) begin fails++; $display("FAIL rstmid_no_resp: got %0d want 0", resp_seen); end
    checks++; if (req_seen !== 0) begin fails++; $display("FAIL rstmid_no_req: got %0d want 0", req_seen); end
    lif.line_address = 32'h0000_3008;
    lif.line_read = 1'b1;
    serve(0, rl, 1'b0, 1'b0);
    checks++; if (rd_seen !== rl) begin fails++; $display("FAIL rstmid_fresh_line: got %h want %h", rd_seen, rl); end
    checks++; if (addr_seen !== 32'h0000_3000) begin fails++; $display("FAIL rstmid_fresh_addr: got %h want 00003000", addr_seen); end
    checks++; if (resp_cycle !== 5) begin fails++; $display("FAIL rstmid_fresh_latency: got %0d want 5", resp_cycle); end
  endtask

  task automatic test_stray_resp();
    logic [255:0] prev;
    logic [255:0] rl4;
    logic [255:0] rl5;
    int           bad;
    prev = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
            64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    rl4 = {64'h4D4D_4D4D_4D4D_4D4D, 64'h4C4C_4C4C_4C4C_4C4C,
           64'h4B4B_4B4B_4B4B_4B4B, 64'h4A4A_4A4A_4A4A_4A4A};
    rl5 = {64'h5D5D_5D5D_5D5D_5D5D, 64'h5C5C_5C5C_5C5C_5C5C,
           64'h5B5B_5B5B_5B5B_5B5B, 64'h5A5A_5A5A_5A5A_5A5A};
    mif.burst_resp = 1'b1;
    mif.burst_rdata = 64'hDEAD_BEEF_BAAD_F00D;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (lif.line_resp || mif.burst_read || mif.burst_write) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL stray_idle_activity: got %0d want 0", bad); end
    checks++; if (lif.line_rdata !== prev) begin fails++; $display("FAIL stray_idle_rdata: got %h want %h", lif.line_rdata, prev); end
    lif.line_address = 32'h0000_4000;
    lif.line_read = 1'b1;
    serve(0, rl4, 1'b1, 1'b0);
    checks++; if (rd_seen !== rl4) begin fails++; $display("FAIL stray_line1: got %h want %h", rd_seen, rl4); end
    checks++; if (resp_cnt !== 1) begin fails++; $display("FAIL stray_resp_cnt1: got %0d want 1", resp_cnt); end
    checks++; if (beats !== 4) begin fails++; $display("FAIL stray_beats1: got %0d want 4", beats); end
    lif.line_address = 32'h0000_5000;
    lif.line_read = 1'b1;
    serve(0, rl5, 1'b1, 1'b0);
    checks++; if (rd_seen !== rl5) begin fails++; $display("FAIL stray_line2: got %h want %h", rd_seen, rl5); end
    checks++; if (resp_cnt !== 1) begin fails++; $display("FAIL stray_resp_cnt2: got %0d want 1", resp_cnt); end
    checks++; if (resp_cycle !== 5) begin fails++; $display("FAIL stray_latency2: got %0d want 5", resp_cycle); end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst = 1'b0;
    lif.line_read = 1'b0;
    lif.line_write = 1'b0;
    lif.line_address = 32'h0;
    lif.line_wdata = 256'h0;
    mif.burst_resp = 1'b0;
    mif.burst_rdata = 64'h0;
    test_reset();
    test_read_basic();
    test_write();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_burst();
    test_stray_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
